alu_result_stage: RTL and testbench

- Sits directly downstream of the 32-bit add/sub unit. Captures its sum, carry-out and overflow, and derives the N/Z/C/V flags.
- Buffers results in a 2-entry skid buffer under valid/ready handshake, so the adder path is cut from writeback.
- Commits the flags to an architectural NZCV register when the result is consumed.
- Maintains a sticky overflow bit.

---
 rtl/alu_result_stage.sv | 169 ++++++++++++++++
 tb/tb_alu_result_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Result stage behind the add/sub unit: derives NZCV, buffers two results, and commits
// flags on dequeue. Define ALU_RESULT_STAGE_OVCNT_EN to add the saturating ov_count output.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_c_out,
    input  logic             in_O,
    input  logic [3:0]       in_f,
    input  logic             in_flag_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic [3:0]       out_nzcv,
    output logic [3:0]       nzcv,
    output logic             sticky_v,
    input  logic             clr_sticky
`ifdef ALU_RESULT_STAGE_OVCNT_EN
    ,
    output logic [15:0]      ov_count
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic [3:0]       nzcv;
        logic             we;
        logic [1:0]       fcls;
    } entry_t;

    localparam logic [1:0] CNT_FULL = 2'(DEPTH);

    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    entry_t     new_ent;
    logic [1:0] cnt_q, cnt_d;
    logic       in_ready_q;
    logic [3:0] nzcv_q, nzcv_d;
    logic       sticky_q, sticky_d;
    logic       enq, deq;
    logic       commit, arith, v_set;
    logic       unused_f;

    assign unused_f = ^in_f[1:0];

    assign in_ready  = in_ready_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_s     = head_q.s;
    assign out_nzcv  = head_q.nzcv;
    assign nzcv      = nzcv_q;
    assign sticky_v  = sticky_q;

    assign enq = in_valid & in_ready_q;
    assign deq = out_valid & out_ready;

    always_comb begin
        new_ent.s    = in_s;
        new_ent.nzcv = {in_s[WIDTH-1], (in_s == '0), in_c_out, in_O};
        new_ent.we   = in_flag_we;
        new_ent.fcls = in_f[3:2];
    end

    // Head register doubles as the output register, so it keeps its last value when empty.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (enq) begin
                    head_d = new_ent;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                case ({enq, deq})
                    2'b10: begin
                        tail_d = new_ent;
                        cnt_d  = 2'd2;
                    end
                    2'b01: cnt_d = 2'd0;
                    2'b11: head_d = new_ent;
                    default: ;
                endcase
            end
            default: begin
                if (deq) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase
    end

    assign commit = deq & head_q.we;
    assign arith  = (head_q.fcls == 2'b00);
    assign v_set  = commit & arith & head_q.nzcv[0];

    always_comb begin
        nzcv_d = nzcv_q;
        if (commit) begin
            nzcv_d[3:2] = head_q.nzcv[3:2];
            if (arith) begin
                nzcv_d[1:0] = head_q.nzcv[1:0];
            end
        end
    end

    always_comb begin
        sticky_d = sticky_q;
        if (v_set) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b1;
            nzcv_q     <= 4'd0;
            sticky_q   <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            in_ready_q <= (cnt_d != CNT_FULL);
            nzcv_q     <= nzcv_d;
            sticky_q   <= sticky_d;
        end
    end

`ifdef ALU_RESULT_STAGE_OVCNT_EN
    logic [15:0] ov_cnt_q, ov_cnt_d;

    // A clear coinciding with an increment leaves exactly that one new event counted.
    always_comb begin
        ov_cnt_d = ov_cnt_q;
        if (v_set) begin
            if (clr_sticky) begin
                ov_cnt_d = 16'd1;
            end else if (ov_cnt_q != 16'hFFFF) begin
                ov_cnt_d = ov_cnt_q + 16'd1;
            end
        end else if (clr_sticky) begin
            ov_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ov_cnt_q <= 16'd0;
        end else begin
            ov_cnt_q <= ov_cnt_d;
        end
    end

    assign ov_count = ov_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; expected values are hand-computed constants.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_s;
    logic        in_c_out;
    logic        in_O;
    logic [3:0]  in_f;
    logic        in_flag_we;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_s;
    logic [3:0]  out_nzcv;
    logic [3:0]  nzcv;
    logic        sticky_v;
    logic        clr_sticky;
`ifdef ALU_RESULT_STAGE_OVCNT_EN
    logic [15:0] ov_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(32), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .in_c_out   (in_c_out),
        .in_O       (in_O),
        .in_f       (in_f),
        .in_flag_we (in_flag_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_nzcv   (out_nzcv),
        .nzcv       (nzcv),
        .sticky_v   (sticky_v),
        .clr_sticky (clr_sticky)
`ifdef ALU_RESULT_STAGE_OVCNT_EN
        ,
        .ov_count   (ov_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] s, input logic c, input logic o,
                         input logic [3:0] f, input logic we);
        in_s       = s;
        in_c_out   = c;
        in_O       = o;
        in_f       = f;
        in_flag_we = we;
    endtask

    // Enqueue one result and let it be consumed (out_ready assumed high).
    task automatic send(input logic [31:0] s, input logic c, input logic o,
                        input logic [3:0] f, input logic we);
        drive(s, c, o, f, we);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        step();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_s", out_s, 32'h0);
        chk("rst_out_nzcv", {28'd0, out_nzcv}, 32'h0);
        chk("rst_nzcv", {28'd0, nzcv}, 32'h0);
        chk("rst_sticky", {31'd0, sticky_v}, 32'd0);

        // zero result: N0 Z1 C1 V0
        out_ready = 1'b1;
        drive(32'h0, 1'b1, 1'b0, 4'b0001, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_out_nzcv", {28'd0, out_nzcv}, 32'h6);
        chk("t1_nzcv_before", {28'd0, nzcv}, 32'h0);
        step();
        chk("t1_nzcv_after", {28'd0, nzcv}, 32'h6);
        chk("t1_empty", {31'd0, out_valid}, 32'd0);
        chk("t1_hold_nzcv", {28'd0, out_nzcv}, 32'h6);

        send(32'h8000_0000, 1'b0, 1'b1, 4'h0, 1'b1);
        chk("t2_nzcv", {28'd0, nzcv}, 32'h9);
        chk("t2_sticky", {31'd0, sticky_v}, 32'd1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("t2_sticky_clr", {31'd0, sticky_v}, 32'd0);
        chk("t2_nzcv_kept", {28'd0, nzcv}, 32'h9);

        // back-to-back under stall
        out_ready = 1'b0;
        drive(32'h1, 1'b0, 1'b0, 4'h0, 1'b0);
        in_valid = 1'b1;
        step();
        chk("t3_ready_one", {31'd0, in_ready}, 32'd1);
        chk("t3_head_a", out_s, 32'h1);
        in_s = 32'h2;
        step();
        chk("t3_ready_full", {31'd0, in_ready}, 32'd0);
        chk("t3_stall_a", out_s, 32'h1);
        in_s = 32'h3;
        step();
        chk("t3_c_blocked", {31'd0, in_ready}, 32'd0);
        chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_stall_a2", out_s, 32'h1);
        out_ready = 1'b1;
        step();
        chk("t3_out_b", out_s, 32'h2);
        chk("t3_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("t3_out_c", out_s, 32'h3);
        chk("t3_c_valid", {31'd0, out_valid}, 32'd1);
        step();
        chk("t3_drained", {31'd0, out_valid}, 32'd0);
        chk("t3_nzcv_untouched", {28'd0, nzcv}, 32'h9);

        // logic-class commit keeps C and V
        send(32'h1, 1'b1, 1'b1, 4'h0, 1'b1);
        chk("t4_seed", {28'd0, nzcv}, 32'h3);
        send(32'h5, 1'b0, 1'b0, 4'b0100, 1'b1);
        chk("t4_logic", {28'd0, nzcv}, 32'h3);
        send(32'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        chk("t4_no_we", {28'd0, nzcv}, 32'h3);
        send(32'h8000_0000, 1'b1, 1'b0, 4'b1000, 1'b1);
        chk("t4_neg_logic", {28'd0, nzcv}, 32'hB);

        // reset with two entries buffered, consumer ready in the reset cycle
        out_ready = 1'b0;
        drive(32'h8000_0000, 1'b1, 1'b1, 4'h0, 1'b1);
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        chk("t5_full", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_nzcv", {28'd0, nzcv}, 32'h0);
        chk("t5_sticky", {31'd0, sticky_v}, 32'd0);
        chk("t5_out_s", out_s, 32'h0);
        step();
        chk("t5_no_stale", {31'd0, out_valid}, 32'd0);
        chk("t5_nzcv_still", {28'd0, nzcv}, 32'h0);

`ifdef ALU_RESULT_STAGE_OVCNT_EN
        for (int i = 0; i < 3; i++) begin
            send(32'h7FFF_FFFF, 1'b0, 1'b1, 4'h0, 1'b1);
        end
        chk("ov_three", {16'd0, ov_count}, 32'd3);
        drive(32'h7FFF_FFFF, 1'b0, 1'b1, 4'h0, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("ov_clr_inc", {16'd0, ov_count}, 32'd1);
        in_valid = 1'b1;
        repeat (65540) step();
        in_valid = 1'b0;
        step();
        step();
        chk("ov_sat", {16'd0, ov_count}, 32'hFFFF);
        send(32'h7FFF_FFFF, 1'b0, 1'b1, 4'h0, 1'b1);
        chk("ov_sat_hold", {16'd0, ov_count}, 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
